// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin arbiter that funnels NUM_PORTS requesters onto
// one backing memory (with ready/timeout handshake) or a single-cycle peripheral
// bus, selected by the top address bit. One transaction in flight at a time.
module memory_port_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic [NUM_PORTS-1:0]             portReq,
    input  logic [NUM_PORTS-1:0]             portWrite,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  portAddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  portWdata,
    output logic [DATA_WIDTH-1:0]            portRdata,
    output logic [NUM_PORTS-1:0]             portDone,
    output logic [NUM_PORTS-1:0]             portError,
    output logic                             memReadEnable,
    output logic                             memWriteEnable,
    output logic [ADDR_WIDTH-1:0]            memAddress,
    output logic [DATA_WIDTH-1:0]            memDataOut,
    input  logic [DATA_WIDTH-1:0]            memDataIn,
    input  logic                             memReady,
    output logic                             periphReadEnable,
    output logic                             periphWriteEnable,
    output logic [ADDR_WIDTH-1:0]            periphAddress,
    output logic [DATA_WIDTH-1:0]            periphDataOut,
    input  logic [DATA_WIDTH-1:0]            periphDataIn
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // Counter only has to reach TIMEOUT_CYCLES-1 (<= 254).
    localparam int CW = 8;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MEM, PERIPH, RESP} state_t;

    state_t                r_state, w_next;
    logic [PW-1:0]         r_rrPtr;
    logic [PW-1:0]         r_grant;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_found;
    logic [PW-1:0]         w_gnt;
    logic [ADDR_WIDTH-1:0] w_selAddr;
    logic [DATA_WIDTH-1:0] w_selWdata;
    logic                  w_timeout;

    // Circular scan for the first requesting port at or after the round-robin pointer.
    always_comb begin : p_scan
        int j;
        j       = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(r_rrPtr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!w_found && portReq[j]) begin
                w_found = 1'b1;
                w_gnt   = PW'(j);
            end
        end
    end

    assign w_selAddr  = portAddr[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_selWdata = portWdata[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
    assign w_timeout  = (r_cnt == LAST_WAIT);

    // State register; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state plus all bus/handshake outputs decoded from the current state.
    always_comb begin
        w_next            = r_state;
        memReadEnable     = 1'b0;
        memWriteEnable    = 1'b0;
        memAddress        = '0;
        memDataOut        = '0;
        periphReadEnable  = 1'b0;
        periphWriteEnable = 1'b0;
        periphAddress     = '0;
        periphDataOut     = '0;
        portDone          = '0;
        portError         = '0;
        case (r_state)
            IDLE: begin
                if (w_found) w_next = w_selAddr[ADDR_WIDTH-1] ? PERIPH : MEM;
            end
            MEM: begin
                memReadEnable  = ~r_write;
                memWriteEnable = r_write;
                memAddress     = r_addr;
                memDataOut     = r_wdata;
                // Ready on the last allowed cycle still wins over the timeout.
                if (memReady || w_timeout) w_next = RESP;
            end
            PERIPH: begin
                periphReadEnable  = ~r_write;
                periphWriteEnable = r_write;
                periphAddress     = r_addr;
                periphDataOut     = r_wdata;
                w_next            = RESP;
            end
            RESP: begin
                portDone[r_grant]  = 1'b1;
                portError[r_grant] = r_err;
                w_next             = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: request latch, wait counter, error flag, read-data capture, rr pointer.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rrPtr <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_gnt;
                        r_addr  <= w_selAddr;
                        r_wdata <= w_selWdata;
                        r_write <= portWrite[w_gnt];
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                MEM: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (memReady) begin
                        r_err <= 1'b0;
                        if (!r_write) r_rdata <= memDataIn;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                PERIPH: begin
                    if (!r_write) r_rdata <= periphDataIn;
                end
                RESP: begin
                    r_rrPtr <= (int'(r_grant) == NUM_PORTS - 1) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign portRdata = r_rdata;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a vector table of single transactions
// plus hand-written sequences for round-robin alternation and mid-MEM reset.
module tb_memory_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rstN;
    logic [NP-1:0]    portReq, portWrite;
    logic [NP*AW-1:0] portAddr;
    logic [NP*DW-1:0] portWdata;
    logic [DW-1:0]    portRdata;
    logic [NP-1:0]    portDone, portError;
    logic             memReadEnable, memWriteEnable;
    logic [AW-1:0]    memAddress;
    logic [DW-1:0]    memDataOut, memDataIn;
    logic             memReady;
    logic             periphReadEnable, periphWriteEnable;
    logic [AW-1:0]    periphAddress;
    logic [DW-1:0]    periphDataOut, periphDataIn;

    memory_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstN(rstN),
        .portReq(portReq), .portWrite(portWrite), .portAddr(portAddr), .portWdata(portWdata),
        .portRdata(portRdata), .portDone(portDone), .portError(portError),
        .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
        .memAddress(memAddress), .memDataOut(memDataOut),
        .memDataIn(memDataIn), .memReady(memReady),
        .periphReadEnable(periphReadEnable), .periphWriteEnable(periphWriteEnable),
        .periphAddress(periphAddress), .periphDataOut(periphDataOut),
        .periphDataIn(periphDataIn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic [31:0] pdata;
        int          lat;        // MEM cycles with memReady low before it goes high; 255 = never
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [1:0]  exp_done;
        int          exp_cyc;    // cycles from IDLE sample edge to done
        int          exp_mem;    // number of MEM strobe cycles
        int          exp_periph; // number of periph strobe cycles
    } vec_t;

    vec_t vecs[8];
    int   nchk  = 0;
    int   npass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else npass++;
    endtask

    task automatic idle_inputs();
        portReq   = '0;
        portWrite = '0;
        memReady  = 1'b0;
    endtask

    // Drive one transaction, emulate memory latency, and check the completion.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc, mcyc, pcyc;
        bit got, busbad;
        logic [1:0] dseen, eseen;
        cyc = 0; mcyc = 0; pcyc = 0; got = 0; busbad = 0; dseen = '0; eseen = '0;
        @(negedge clk);
        idle_inputs();
        portReq[v.port]            = 1'b1;
        portWrite[v.port]          = v.wr;
        portAddr[v.port*AW +: AW]  = v.addr;
        portWdata[v.port*DW +: DW] = v.wdata;
        memDataIn    = v.mdata;
        periphDataIn = v.pdata;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            portReq  = '0;   // dropping the request must not abort the transaction
            memReady = 1'b0;
            if (memReadEnable || memWriteEnable) begin
                if (memAddress !== v.addr || memReadEnable === v.wr ||
                    (v.wr && memDataOut !== v.wdata) || periphReadEnable || periphWriteEnable)
                    busbad = 1;
                memReady = (mcyc == v.lat);
                mcyc++;
            end
            if (periphReadEnable || periphWriteEnable) begin
                if (periphAddress !== v.addr || periphWriteEnable !== v.wr ||
                    (v.wr && periphDataOut !== v.wdata))
                    busbad = 1;
                pcyc++;
            end
            if (portDone != 0) begin
                got   = 1;
                dseen = portDone;
                eseen = portError;
                if (memReadEnable || memWriteEnable || periphReadEnable || periphWriteEnable)
                    busbad = 1;
            end
        end
        chk({tag, " latency"},   32'(cyc),   32'(v.exp_cyc));
        chk({tag, " done"},      32'(dseen), 32'(v.exp_done));
        chk({tag, " error"},     32'(eseen), v.exp_err ? 32'(v.exp_done) : 32'd0);
        chk({tag, " rdata"},     portRdata,  v.exp_rdata);
        chk({tag, " memcycles"}, 32'(mcyc),  32'(v.exp_mem));
        chk({tag, " pcycles"},   32'(pcyc),  32'(v.exp_periph));
        chk({tag, " bus"},       32'(busbad), 32'd0);
        @(posedge clk); #1;
        chk({tag, " done_clear"}, 32'(portDone), 32'd0);
        chk({tag, " rdata_hold"}, portRdata, v.exp_rdata);
    endtask

    // Wait (bounded) for the next done pulse; returns 0 on expiry.
    task automatic wait_done(output logic [1:0] d, output int cyc);
        d = '0; cyc = 0;
        while (d == 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (portDone != 0) d = portDone;
        end
    endtask

    initial begin
        logic [1:0] d;
        int cyc, last, ndone;
        logic [1:0] exp_seq[4];
        vec_t pre;

        //             wr port addr          wdata         mdata         pdata         lat  exp_rdata     err done cyc mem per
        vecs[0] = '{1'b0, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0,        0,   32'hDEAD_BEEF, 1'b0, 2'b01, 2,  1,  0};
        vecs[1] = '{1'b1, 1, 32'h8000_0004, 32'h0000_005A, 32'h0,        32'hFFFF_FFFF, 0,   32'hDEAD_BEEF, 1'b0, 2'b10, 2,  0,  1};
        vecs[2] = '{1'b0, 1, 32'h8000_0010, 32'h0,        32'h0,        32'h1234_5678, 0,   32'h1234_5678, 1'b0, 2'b10, 2,  0,  1};
        vecs[3] = '{1'b1, 0, 32'h0000_0200, 32'h0000_00AA, 32'h5555_5555, 32'h0,        3,   32'h1234_5678, 1'b0, 2'b01, 5,  4,  0};
        vecs[4] = '{1'b0, 0, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 32'h0,        15,  32'hCAFE_F00D, 1'b0, 2'b01, 17, 16, 0};
        vecs[5] = '{1'b0, 1, 32'h0000_0040, 32'h0,        32'h9999_9999, 32'h0,        255, 32'h0,        1'b1, 2'b10, 17, 16, 0};
        vecs[6] = '{1'b0, 0, 32'h0000_0044, 32'h0,        32'h1111_2222, 32'h0,        1,   32'h1111_2222, 1'b0, 2'b01, 3,  2,  0};
        vecs[7] = '{1'b1, 1, 32'h0000_0048, 32'h0000_0077, 32'h0,        32'h0,        255, 32'h0,        1'b1, 2'b10, 17, 16, 0};

        rstN = 1'b0;
        idle_inputs();
        portAddr = '0; portWdata = '0; memDataIn = '0; periphDataIn = '0;
        @(negedge clk);
        chk("reset done",    32'(portDone), 32'd0);
        chk("reset strobes", 32'({memReadEnable, memWriteEnable, periphReadEnable, periphWriteEnable}), 32'd0);
        chk("reset rdata",   portRdata, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both ports requesting continuously: grants alternate, done every 3 cycles.
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge clk);
        portReq = 2'b11; portWrite = 2'b00;
        portAddr = {32'h0000_0020, 32'h0000_0010};
        memDataIn = 32'hA5A5_0001;
        memReady = 1'b1;
        cyc = 0; last = 0; ndone = 0;
        while (ndone < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (portDone != 0) begin
                chk($sformatf("rr grant%0d", ndone), 32'(portDone), 32'(exp_seq[ndone]));
                if (ndone > 0) chk($sformatf("rr gap%0d", ndone), 32'(cyc - last), 32'd3);
                else           chk("rr first", 32'(cyc), 32'd2);
                last = cyc;
                ndone++;
                if (ndone == 4) portReq = '0;
            end
        end
        chk("rr count", 32'(ndone), 32'd4);
        memReady = 1'b0;
        @(posedge clk); #1;

        // Leave rrPtr at 1, then reset during the third MEM cycle of a port-0 read.
        pre = '{1'b0, 0, 32'h0000_0500, 32'h0, 32'h7777_7777, 32'h0, 0, 32'h7777_7777, 1'b0, 2'b01, 2, 1, 0};
        run_vec(pre, "pre");
        @(negedge clk);
        portReq = 2'b01; portWrite = 2'b00;
        portAddr = {32'h0000_0700, 32'h0000_0600};
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        portReq = '0;
        chk("mem3 strobe", 32'(memReadEnable), 32'd1);
        chk("mem3 addr", memAddress, 32'h0000_0600);
        #2 rstN = 1'b0;
        #1;
        chk("rst strobes", 32'({memReadEnable, memWriteEnable, periphReadEnable, periphWriteEnable}), 32'd0);
        chk("rst rdata", portRdata, 32'd0);
        ndone = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (portDone != 0) ndone++;
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        if (portDone != 0) ndone++;
        chk("rst no done", 32'(ndone), 32'd0);

        // rrPtr back at 0: with both requesting, port 0 wins; then port 1 alone.
        @(negedge clk);
        portReq = 2'b11;
        memDataIn = 32'h0BAD_CAFE;
        memReady = 1'b1;
        wait_done(d, cyc);
        portReq = '0;
        chk("post-rst both", 32'(d), 32'd1);
        chk("post-rst lat", 32'(cyc), 32'd2);
        chk("post-rst rdata", portRdata, 32'h0BAD_CAFE);
        @(negedge clk);
        portReq = 2'b10;
        wait_done(d, cyc);
        portReq = '0;
        chk("post-rst p1", 32'(d), 32'd2);
        memReady = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
